// File: rtl/phy_rx_pkg.sv
// Shared constants, FSM state type and lane helper for the phy_rx receive path.
package phy_rx_pkg;

  localparam logic [7:0] COMMA_DEF      = 8'hBC;
  localparam int         LOCK_COUNT_DEF = 4;
  localparam int         NUM_LANES      = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_e;

  function automatic logic [1:0] lane_next(input logic [1:0] lane);
    return lane + 2'd1;
  endfunction

endpackage

// File: rtl/serial_paralelo_rx.sv
// Serial-to-byte converter: comma hunt, lock qualification and byte-boundary strobe.
module serial_paralelo_rx
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEF,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       serial_i,
  output logic [7:0] byte_out,
  output logic       byte_stb,
  output logic       active
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  state_e     state_q, state_d;
  logic [7:0] sr_q;
  logic [7:0] nb_s;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] comma_cnt_q, comma_cnt_d;
  logic       is_comma_s;
  logic       boundary_s;

  assign nb_s       = {sr_q[6:0], serial_i};
  assign is_comma_s = (nb_s == COMMA);
  assign boundary_s = (bit_cnt_q == 3'd7);
  assign byte_out   = nb_s;
  assign active     = (state_q == ACTIVE);

  // Next-state logic for the hunt/lock/active sequence.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    byte_stb    = 1'b0;
    case (state_q)
      HUNT: begin
        bit_cnt_d = 3'd0;
        if (is_comma_s) begin
          state_d     = LOCKING;
          comma_cnt_d = 4'd1;
        end else begin
          comma_cnt_d = 4'd0;
        end
      end
      LOCKING: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary_s) begin
          if (is_comma_s) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if (comma_cnt_d == LOCK_CNT) begin
              state_d = ACTIVE;
            end else begin
              state_d = LOCKING;
            end
          end else begin
            state_d     = HUNT;
            comma_cnt_d = 4'd0;
          end
        end else begin
          state_d = LOCKING;
        end
      end
      ACTIVE: begin
        // No loss-of-lock path: only reset leaves this state.
        bit_cnt_d = bit_cnt_q + 3'd1;
        byte_stb  = boundary_s;
      end
      default: begin
        state_d     = HUNT;
        bit_cnt_d   = 3'd0;
        comma_cnt_d = 4'd0;
      end
    endcase
  end

  // State, counters and shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= HUNT;
      sr_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      comma_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      sr_q        <= nb_s;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
    end
  end

endmodule

// File: rtl/phy_rx.sv
// PHY receive top: recovers four striped lanes from the serial stream.
// Optional PHY_RX_HOLD_EN: a lane receiving a comma keeps its previous data byte.
module phy_rx
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEF,
  parameter int         LOCK_COUNT = LOCK_COUNT_DEF
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       in_serial,
  output logic       active,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [7:0] data_out2,
  output logic [7:0] data_out3,
  output logic       valid_out0,
  output logic       valid_out1,
  output logic       valid_out2,
  output logic       valid_out3
);

  logic [7:0]           byte_s;
  logic                 byte_stb_s;
  logic [1:0]           lane_cnt_q, lane_cnt_d;
  logic [7:0]           data_q [NUM_LANES];
  logic [7:0]           data_d [NUM_LANES];
  logic [NUM_LANES-1:0] valid_q, valid_d;

  serial_paralelo_rx #(
    .COMMA      (COMMA),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_sp (
    .clk_i    (clk_32f),
    .rst_ni   (reset),
    .serial_i (in_serial),
    .byte_out (byte_s),
    .byte_stb (byte_stb_s),
    .active   (active)
  );

  // Route each boundary byte to the current lane; other lanes hold.
  always_comb begin
    lane_cnt_d = lane_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    if (byte_stb_s) begin
      lane_cnt_d          = lane_next(lane_cnt_q);
      valid_d[lane_cnt_q] = (byte_s != COMMA);
      if (byte_s != COMMA) begin
        data_d[lane_cnt_q] = byte_s;
      end else begin
`ifdef PHY_RX_HOLD_EN
        data_d[lane_cnt_q] = data_q[lane_cnt_q];
`else
        data_d[lane_cnt_q] = 8'h00;
`endif
      end
    end else begin
      lane_cnt_d = lane_cnt_q;
    end
  end

  // Lane output registers and round-robin pointer.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      lane_cnt_q <= 2'd0;
      valid_q    <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        data_q[i] <= 8'h00;
      end
    end else begin
      lane_cnt_q <= lane_cnt_d;
      valid_q    <= valid_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign data_out0  = data_q[0];
  assign data_out1  = data_q[1];
  assign data_out2  = data_q[2];
  assign data_out3  = data_q[3];
  assign valid_out0 = valid_q[0];
  assign valid_out1 = valid_q[1];
  assign valid_out2 = valid_q[2];
  assign valid_out3 = valid_q[3];

endmodule

// File: tb/tb_phy_rx.sv
// Self-checking bench for phy_rx: directed scenarios plus randomized streams
// compared every cycle against a position-based model of comma lock and lane striping.
module tb_phy_rx;

  localparam logic [7:0] BC     = 8'hBC;
  localparam int         LOCK_N = 4;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       in_serial;
  logic       active;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: edge index since reset, last 8 bits, edge of first comma / lock.
  int         edge_n;
  logic [7:0] win;
  int         lock_start;
  int         locked_at;
  logic [7:0] m_data [4];
  logic [3:0] m_valid;

  logic [7:0] dut_data [4];
  logic [3:0] dut_valid;

  phy_rx dut (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .in_serial  (in_serial),
    .active     (active),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .valid_out3 (valid_out3)
  );

  always #5 clk_32f = ~clk_32f;

  assign dut_data[0] = data_out0;
  assign dut_data[1] = data_out1;
  assign dut_data[2] = data_out2;
  assign dut_data[3] = data_out3;
  assign dut_valid   = {valid_out3, valid_out2, valid_out1, valid_out0};

  task automatic check(input string name, input int lane, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane %0d at %0t: got %h expected %h", name, lane, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    edge_n     = 0;
    win        = 8'h00;
    lock_start = -1;
    locked_at  = -1;
    m_valid    = 4'h0;
    for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
  endtask

  task automatic model_step(input logic b);
    int lane;
    edge_n++;
    win = {win[6:0], b};
    if (locked_at >= 0) begin
      if ((edge_n - locked_at) % 8 == 0) begin
        lane = ((edge_n - locked_at) / 8 - 1) % 4;
        m_valid[lane] = (win != BC);
        if (win != BC) begin
          m_data[lane] = win;
        end else begin
`ifndef PHY_RX_HOLD_EN
          m_data[lane] = 8'h00;
`endif
        end
      end
    end else if (lock_start < 0) begin
      if (win == BC) lock_start = edge_n;
    end else if ((edge_n - lock_start) % 8 == 0) begin
      if (win != BC) lock_start = -1;
      else if ((edge_n - lock_start) / 8 + 1 == LOCK_N) locked_at = edge_n;
    end
  endtask

  // Single compare process: DUT outputs vs model, sampled mid-cycle.
  always @(negedge clk_32f) begin
    if (chk_en) begin
      check("active", 0, {7'd0, active}, {7'd0, (locked_at >= 0)});
      for (int i = 0; i < 4; i++) begin
        check("data", i, dut_data[i], m_data[i]);
        check("valid", i, {7'd0, dut_valid[i]}, {7'd0, m_valid[i]});
      end
    end
  end

  task automatic send_bit(input logic b);
    in_serial = b;
    @(posedge clk_32f);
    #1;
    model_step(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b0;
    in_serial = 1'b0;
    model_reset();
    repeat (n) @(posedge clk_32f);
    #1;
    check("rst_active", 0, {7'd0, active}, 8'h00);
    check("rst_data", 2, data_out2, 8'h00);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] hold_exp;
    logic [7:0] bits;
    reset     = 1'b1;
    in_serial = 1'b0;
    model_reset();
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Reset then lock: active rises on edge 32.
    do_reset(3);
    repeat (3) send_byte(BC);
    bits = BC;
    for (int i = 7; i >= 1; i--) send_bit(bits[i]);
    check("lock_edge31", 0, {7'd0, active}, 8'h00);
    send_bit(bits[0]);
    check("lock_edge32", 0, {7'd0, active}, 8'h01);
    check("lock_lane0", 0, data_out0, 8'h00);

    // Rejected attempt, then a clean lock.
    do_reset(2);
    repeat (3) send_byte(BC);
    send_byte(8'h12);
    check("reject", 0, {7'd0, active}, 8'h00);
    repeat (4) send_byte(BC);
    check("relock", 0, {7'd0, active}, 8'h01);

    // Unaligned start, data, comma on a lane, wrap-around.
    do_reset(1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (4) send_byte(BC);
    check("unal_active", 0, {7'd0, active}, 8'h01);
    send_byte(8'hCC);
    check("unal_d0", 0, data_out0, 8'hCC);
    check("unal_d1", 1, data_out1, 8'h00);
    send_byte(8'hFD); send_byte(8'hAA); send_byte(8'h12);
    check("unal_d1b", 1, data_out1, 8'hFD);
    check("unal_d2", 2, data_out2, 8'hAA);
    check("unal_d3", 3, data_out3, 8'h12);
    check("unal_v", 0, {4'd0, dut_valid}, 8'h0F);
    send_byte(BC);
`ifdef PHY_RX_HOLD_EN
    hold_exp = 8'hCC;
`else
    hold_exp = 8'h00;
`endif
    check("comma_d0", 0, data_out0, hold_exp);
    check("comma_v", 0, {4'd0, dut_valid}, 8'h0E);
    send_byte(8'hFD); send_byte(8'hAA); send_byte(8'h12);
    for (int k = 1; k <= 8; k++) begin
      send_byte(8'(k));
      if (k == 1) check("wrap_d0a", 0, data_out0, 8'h01);
      if (k == 4) check("wrap_d3a", 3, data_out3, 8'h04);
    end
    check("wrap_d0b", 0, data_out0, 8'h05);
    check("wrap_d3b", 3, data_out3, 8'h08);

    // Asynchronous reset mid-byte while active.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #1 reset = 1'b0;
    model_reset();
    #1;
    check("async_active", 0, {7'd0, active}, 8'h00);
    check("async_d3", 3, data_out3, 8'h00);
    repeat (2) @(posedge clk_32f);
    #1 reset = 1'b1;
    repeat (3) send_byte(BC);
    check("async_relock3", 0, {7'd0, active}, 8'h00);
    send_byte(BC);
    check("async_relock4", 0, {7'd0, active}, 8'h01);

    // Randomized streams with comma runs, misalignment and stray commas.
    for (int r = 0; r < 6; r++) begin
      do_reset(int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 20)) send_bit(1'($urandom));
      for (int k = 0; k < 40; k++) begin
        case ($urandom % 5)
          0: repeat ($urandom_range(1, 5)) send_byte(BC);
          1: send_bit(1'($urandom));
          2: send_byte(BC);
          default: send_byte(8'($urandom));
        endcase
      end
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
